// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// UART receiver driven by a 16x-baud oversampling strobe. The generator output
// is treated as a level; each rising edge becomes a one-cycle tick. The start
// bit is verified at mid-bit, then every data/parity/stop bit is sampled 16
// ticks after the previous sample. The received word and its status flags are
// presented together with a one-cycle rx_valid strobe.
module uart_rx_oversample #(
    parameter int pDATA_BITS  = 8,
    parameter int pPARITY_EN  = 0,
    parameter int pPARITY_ODD = 0
) (
    input  logic                  sys_clk,
    input  logic                  Async_rst,
    input  logic                  baud_clk_16x,
    input  logic                  rx_in,
    output logic [pDATA_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  rx_busy
);

    localparam int                BCNT_W    = (pDATA_BITS > 1) ? $clog2(pDATA_BITS) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(pDATA_BITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic              PAR_EN    = (pPARITY_EN != 0);
    localparam logic              PAR_ODD   = (pPARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even-parity reduction of a received word.
    function automatic logic parity_of(input logic [pDATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic                  rx_meta_r;
    logic                  rx_s;
    logic                  baud_q;
    logic                  tick_s;
    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [BCNT_W-1:0]     bcnt_r;
    logic [pDATA_BITS-1:0] sh_r;
    logic                  par_bit_r;
    logic                  line_ok_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_s      <= rx_meta_r;
        end
    end

    // Delayed copy of the baud level, used to find its rising edges.
    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_clk_16x;
        end
    end

    assign tick_s = baud_clk_16x & ~baud_q;

    // Receive FSM with registered outputs; it advances only on tick cycles.
    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            bcnt_r     <= '0;
            sh_r       <= '0;
            par_bit_r  <= 1'b0;
            line_ok_r  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_busy  <= (state_r != IDLE);
            if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        // line_ok only rises after the line has been seen high,
                        // so a line stuck low cannot retrigger a frame.
                        line_ok_r <= rx_s;
                        if (!rx_s && line_ok_r) begin
                            cnt_r   <= 4'd0;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    START: begin
                        if (cnt_r != 4'd7) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else if (!rx_s) begin
                            cnt_r   <= 4'd0;
                            bcnt_r  <= '0;
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        if (cnt_r != 4'd15) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            sh_r  <= {rx_s, sh_r[pDATA_BITS-1:1]};
                            cnt_r <= 4'd0;
                            if (bcnt_r == BCNT_LAST) begin
                                if (PAR_EN) begin
                                    state_r <= PARITY;
                                end else begin
                                    state_r <= STOP;
                                end
                            end else begin
                                bcnt_r <= bcnt_r + BCNT_ONE;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt_r != 4'd15) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            par_bit_r <= rx_s;
                            cnt_r     <= 4'd0;
                            state_r   <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt_r != 4'd15) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            rx_data    <= sh_r;
                            frame_err  <= ~rx_s;
                            parity_err <= PAR_EN ? (parity_of(sh_r) ^ par_bit_r ^ PAR_ODD) : 1'b0;
                            rx_valid   <= 1'b1;
                            line_ok_r  <= 1'b0;
                            cnt_r      <= 4'd0;
                            state_r    <= IDLE;
                        end
                    end
                    default: begin
                        cnt_r   <= 4'd0;
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Testbench for uart_rx_oversample: one 8N1 instance (dut A) and one 8E1
// instance (dut B). Expected words are queued when a frame is driven and
// compared whenever a DUT strobes rx_valid.
module tb_uart_rx_oversample;

    localparam int BIT_CYC = 128;

    logic       sys_clk = 1'b0;
    logic       Async_rst = 1'b0;
    logic       baud_clk_16x = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       frame_err_a, frame_err_b;
    logic       parity_err_a, parity_err_b;
    logic       rx_busy_a, rx_busy_b;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[8];

    uart_rx_oversample #(.pDATA_BITS(8), .pPARITY_EN(0), .pPARITY_ODD(0)) dut_a (
        .sys_clk(sys_clk), .Async_rst(Async_rst), .baud_clk_16x(baud_clk_16x), .rx_in(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a),
        .parity_err(parity_err_a), .rx_busy(rx_busy_a)
    );

    uart_rx_oversample #(.pDATA_BITS(8), .pPARITY_EN(1), .pPARITY_ODD(0)) dut_b (
        .sys_clk(sys_clk), .Async_rst(Async_rst), .baud_clk_16x(baud_clk_16x), .rx_in(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b),
        .parity_err(parity_err_b), .rx_busy(rx_busy_b)
    );

    // sys_clk: period 10
    always #5 sys_clk = ~sys_clk;

    // baud generator: 8 sys_clk period, 4 high / 4 low, edges away from sys_clk edges
    initial begin
        forever begin
            baud_clk_16x = 1'b1;
            #40;
            baud_clk_16x = 1'b0;
            #40;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%02h required=%02h", name, act, req);
        end
    endtask

    task automatic score(input int sel, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        int   empty;
        checks++;
        if (sel == 0) empty = (q_a.size() == 0) ? 1 : 0;
        else          empty = (q_b.size() == 0) ? 1 : 0;
        if (empty != 0) begin
            failures++;
            $display("FAIL unexpected_valid dut%0d got data=%02h fe=%0b pe=%0b required no strobe", sel, d, fe, pe);
        end else begin
            if (sel == 0) e = q_a.pop_front();
            else          e = q_b.pop_front();
            if (d !== e.data || fe !== e.fe || pe !== e.pe) begin
                failures++;
                $display("FAIL rx_word dut%0d got data=%02h fe=%0b pe=%0b required data=%02h fe=%0b pe=%0b",
                         sel, d, fe, pe, e.data, e.fe, e.pe);
            end
        end
    endtask

    // Scoreboard monitor: sample strobes on the falling edge
    always @(negedge sys_clk) begin
        if (rx_valid_a === 1'b1) score(0, rx_data_a, frame_err_a, parity_err_a);
        if (rx_valid_b === 1'b1) score(1, rx_data_b, frame_err_b, parity_err_b);
    end

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (BIT_CYC) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_exp(input int sel, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (use_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    initial begin
        logic [7:0] abort_byte;
        bit         seen_low;

        // sel, data, par_bit, stop_bit, exp_data, exp_fe, exp_pe
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};

        // Reset, then idle line for 2 bit times
        repeat (4) @(posedge sys_clk);
        #1;
        Async_rst = 1'b1;
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        chk("reset_rx_data_a", rx_data_a, 8'h00);
        chk("reset_rx_valid_a", {7'd0, rx_valid_a}, 8'h00);
        chk("reset_frame_err_a", {7'd0, frame_err_a}, 8'h00);
        chk("reset_parity_err_a", {7'd0, parity_err_a}, 8'h00);
        chk("reset_rx_busy_a", {7'd0, rx_busy_a}, 8'h00);
        chk("reset_rx_data_b", rx_data_b, 8'h00);
        chk("reset_rx_busy_b", {7'd0, rx_busy_b}, 8'h00);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            push_exp(int'(vecs[i].sel), vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe);
            send_frame(int'(vecs[i].sel), vecs[i].data, vecs[i].sel, vecs[i].par_bit, vecs[i].stop_bit);
            drive_bit(int'(vecs[i].sel), 1'b1);
            drive_bit(int'(vecs[i].sel), 1'b1);
            if (vecs[i].sel == 1'b0) chk("busy_after_frame_a", {7'd0, rx_busy_a}, 8'h00);
            else                     chk("busy_after_frame_b", {7'd0, rx_busy_b}, 8'h00);
        end

        // Glitch: 3 ticks low, then high
        rx_a = 1'b0;
        repeat (24) @(posedge sys_clk);
        #1;
        chk("glitch_busy_high", {7'd0, rx_busy_a}, 8'h01);
        rx_a = 1'b1;
        seen_low = 1'b0;
        for (int c = 0; c < 72; c++) begin
            @(negedge sys_clk);
            if (rx_busy_a == 1'b0) seen_low = 1'b1;
        end
        chk("glitch_busy_low_within_9_ticks", {7'd0, seen_low}, 8'h01);
        drive_bit(0, 1'b1);

        // Frame error then line stuck low for 20 bit times
        push_exp(0, 8'h3C, 1'b1, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++) drive_bit(0, 1'b0);
        chk("stuck_low_rx_data", rx_data_a, 8'h3C);
        chk("stuck_low_frame_err", {7'd0, frame_err_a}, 8'h01);
        chk("stuck_low_busy", {7'd0, rx_busy_a}, 8'h00);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        push_exp(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        chk("recover_frame_err", {7'd0, frame_err_a}, 8'h00);

        // Async reset during data bit 4 of 0xF0
        abort_byte = 8'hF0;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, abort_byte[i]);
        rx_a = abort_byte[4];
        repeat (64) @(posedge sys_clk);
        #1;
        chk("abort_busy_before", {7'd0, rx_busy_a}, 8'h01);
        #2;
        Async_rst = 1'b0;
        #1;
        chk("abort_rx_busy_a", {7'd0, rx_busy_a}, 8'h00);
        chk("abort_rx_data_a", rx_data_a, 8'h00);
        chk("abort_rx_valid_a", {7'd0, rx_valid_a}, 8'h00);
        chk("abort_rx_data_b", rx_data_b, 8'h00);
        chk("abort_frame_err_b", {7'd0, frame_err_b}, 8'h00);
        chk("abort_parity_err_b", {7'd0, parity_err_b}, 8'h00);
        repeat (3) @(posedge sys_clk);
        #1;
        Async_rst = 1'b1;
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);

        // Back-to-back frames with no idle gap
        push_exp(0, 8'h01, 1'b0, 1'b0);
        push_exp(0, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        chk("b2b_last_data", rx_data_a, 8'hFF);

        // Every queued frame must have been received
        chk("leftover_a", 8'(q_a.size()), 8'h00);
        chk("leftover_b", 8'(q_b.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
